garuda_mac_issue_ctrl: RTL and testbench

Coprocessor-side controller that sequences Garuda custom-3 MAC instructions issued by CVA6 over a simplified CV-X-IF (issue / commit / result).
- Decodes the instruction and owns the architectural 32-bit accumulator.
- Time-shares a single signed 8x8 multiplier across the lanes of multi-lane ops.
- Applies the accumulator update only after a non-killed commit.
- Sits between the CVA6 X-IF port and the Garuda MAC datapath; handles one instruction in flight.

---
 rtl/garuda_pkg.sv | 55 +++++
 rtl/garuda_mul8.sv | 29 ++
 rtl/garuda_mac_issue_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_garuda_mac_issue_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/garuda_pkg.sv
// Shared definitions for the Garuda custom-3 MAC coprocessor.
// Holds the instruction encodings, op/state enums and the instruction decoder
// used by the issue controller.
package garuda_pkg;

  localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
  localparam logic [2:0] FUNCT3_GARUDA  = 3'b000;

  localparam logic [6:0] FUNCT7_MAC8   = 7'h00;
  localparam logic [6:0] FUNCT7_DOT4   = 7'h01;
  localparam logic [6:0] FUNCT7_CLRACC = 7'h02;

  localparam int unsigned MUL_W  = 8;
  localparam int unsigned PROD_W = 2 * MUL_W;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned OPND_W = LANES * MUL_W;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [1:0] {
    OP_MAC8,
    OP_DOT4,
    OP_CLRACC
  } garuda_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_COMMIT,
    RESULT
  } ctrl_state_e;

  typedef struct packed {
    logic       valid;
    garuda_op_e op;
  } decode_t;

  // Classify a raw instruction word; valid=0 means the word is not ours.
  function automatic decode_t decode_instr(input logic [INSN_W-1:0] instr);
    decode_t dec;
    dec.valid = 1'b0;
    dec.op    = OP_MAC8;
    if ((instr[6:0] == OPCODE_CUSTOM3) && (instr[14:12] == FUNCT3_GARUDA)) begin
      unique case (instr[31:25])
        FUNCT7_MAC8:   begin dec.valid = 1'b1; dec.op = OP_MAC8;   end
        FUNCT7_DOT4:   begin dec.valid = 1'b1; dec.op = OP_DOT4;   end
        FUNCT7_CLRACC: begin dec.valid = 1'b1; dec.op = OP_CLRACC; end
        default:       begin dec.valid = 1'b0; dec.op = OP_MAC8;   end
      endcase
    end
    return dec;
  endfunction

endpackage

// File: rtl/garuda_mul8.sv
// Shared signed 8x8 multiplier with a byte-lane select on both operands.
// Ports:
//   a_i, b_i  packed 4-lane operands (lane k = bits [8k+7:8k])
//   lane_i    lane to multiply
//   prod_o    signed 16-bit product (combinational)
module garuda_mul8
  import garuda_pkg::*;
(
  input  logic        [OPND_W-1:0] a_i,
  input  logic        [OPND_W-1:0] b_i,
  input  logic        [LANE_W-1:0] lane_i,
  output logic signed [PROD_W-1:0] prod_o
);

  logic signed [MUL_W-1:0]  a_lane;
  logic signed [MUL_W-1:0]  b_lane;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  // Lane select, then sign-extend so the low 16 bits of the product are exact.
  always_comb begin
    a_lane = a_i[{lane_i, 3'b000} +: MUL_W];
    b_lane = b_i[{lane_i, 3'b000} +: MUL_W];
    a_ext  = {{(PROD_W-MUL_W){a_lane[MUL_W-1]}}, a_lane};
    b_ext  = {{(PROD_W-MUL_W){b_lane[MUL_W-1]}}, b_lane};
    prod_o = a_ext * b_ext;
  end

endmodule

// File: rtl/garuda_mac_issue_ctrl.sv
// Garuda MAC issue controller: accepts custom-3 MAC instructions over a
// simplified X-IF, sequences the shared multiplier over the operand lanes,
// and applies the accumulator update only once a non-killed commit arrives.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   issue_*                       issue handshake (instr, id, rs1, rs2, accept)
//   commit_*                      commit/kill notice for the in-flight id
//   result_*                      result offer (id, rd, data) with ready
//   busy_o                        an instruction is in flight
module garuda_mac_issue_ctrl
  import garuda_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [INSN_W-1:0]   issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [RD_W-1:0]     result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                busy_o
);

  ctrl_state_e          state_q, state_d;
  garuda_op_e           op_q, op_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] temp_q, temp_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic                 seen_q, seen_d;
  logic                 kill_q, kill_d;
  logic                 ready_q, ready_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [RD_W-1:0]      rd_q, rd_d;
  logic [OPND_W-1:0]    rs1_q, rs1_d;
  logic [OPND_W-1:0]    rs2_q, rs2_d;

  decode_t                    dec;
  logic                       issue_hs;
  logic                       commit_match;
  logic                       exec_last;
  logic                       seen_any;
  logic                       kill_any;
  logic signed [PROD_W-1:0]   prod;
  logic [ACC_WIDTH-1:0]       prod_ext;
  logic [ACC_WIDTH-1:0]       temp_next;

  garuda_mul8 u_mul8 (
    .a_i    (rs1_q),
    .b_i    (rs2_q),
    .lane_i (lane_q),
    .prod_o (prod)
  );

  // Issue-side decode and handshake; ready_q is only ever set in IDLE.
  always_comb begin
    dec      = decode_instr(issue_instr_i);
    issue_hs = issue_valid_i & ready_q;
  end

  // Next-state logic for the sequencer, accumulator and commit tracking.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    temp_d  = temp_q;
    lane_d  = lane_q;
    seen_d  = seen_q;
    kill_d  = kill_q;
    id_d    = id_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;

    commit_match = commit_valid_i && (commit_id_i == id_q);
    prod_ext     = ACC_WIDTH'(prod);
    temp_next    = (op_q == OP_CLRACC) ? '0 : (temp_q + prod_ext);
    exec_last    = (op_q != OP_DOT4) || (lane_q == LANE_W'(LANES - 1));
    // An earlier latched commit wins over anything arriving now.
    seen_any     = seen_q || commit_match;
    kill_any     = seen_q ? kill_q : commit_kill_i;

    unique case (state_q)
      IDLE: begin
        seen_d = 1'b0;
        kill_d = 1'b0;
        if (issue_hs && dec.valid) begin
          op_d   = dec.op;
          id_d   = issue_id_i;
          rd_d   = issue_instr_i[11:7];
          rs1_d  = issue_rs1_i[OPND_W-1:0];
          rs2_d  = issue_rs2_i[OPND_W-1:0];
          temp_d = acc_q;
          lane_d = '0;
          // A commit presented alongside the issue belongs to this instruction.
          if (commit_valid_i && (commit_id_i == issue_id_i)) begin
            seen_d = 1'b1;
            kill_d = commit_kill_i;
          end
          state_d = EXEC;
        end
      end

      EXEC: begin
        temp_d = temp_next;
        lane_d = exec_last ? '0 : (lane_q + LANE_W'(1));
        if (commit_match && !seen_q) begin
          seen_d = 1'b1;
          kill_d = commit_kill_i;
        end
        if (seen_any && kill_any) begin
          lane_d  = '0;
          state_d = IDLE;
        end else if (exec_last) begin
          if (seen_any) begin
            acc_d   = temp_next;
            state_d = RESULT;
          end else begin
            state_d = WAIT_COMMIT;
          end
        end
      end

      WAIT_COMMIT: begin
        if (commit_match) begin
          if (commit_kill_i) begin
            state_d = IDLE;
          end else begin
            acc_d   = temp_q;
            state_d = RESULT;
          end
        end
      end

      RESULT: begin
        if (result_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= OP_MAC8;
      acc_q   <= '0;
      temp_q  <= '0;
      lane_q  <= '0;
      seen_q  <= 1'b0;
      kill_q  <= 1'b0;
      ready_q <= 1'b0;
      id_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      temp_q  <= temp_d;
      lane_q  <= lane_d;
      seen_q  <= seen_d;
      kill_q  <= kill_d;
      ready_q <= ready_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  // Accept/writeback are handshake-cycle responses and must be combinational.
  always_comb begin
    issue_ready_o     = ready_q;
    issue_accept_o    = issue_hs & dec.valid;
    issue_writeback_o = issue_hs & dec.valid;
    result_valid_o    = (state_q == RESULT);
    result_id_o       = id_q;
    result_rd_o       = rd_q;
    result_data_o     = XLEN'(temp_q);
    busy_o            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_garuda_mac_issue_ctrl.sv
// Scoreboard bench for garuda_mac_issue_ctrl: stimulus pushes expected results
// computed by an arithmetic reference model, a monitor pops on each result
// handshake and also watches result stability under backpressure.
module tb_garuda_mac_issue_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IDW  = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i;
  logic [IDW-1:0]  issue_id_i;
  logic [XLEN-1:0] issue_rs1_i;
  logic [XLEN-1:0] issue_rs2_i;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            commit_valid_i;
  logic [IDW-1:0]  commit_id_i;
  logic            commit_kill_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [IDW-1:0]  result_id_o;
  logic [4:0]      result_rd_o;
  logic [XLEN-1:0] result_data_o;
  logic            busy_o;

  garuda_mac_issue_ctrl #(.XLEN(XLEN), .ID_WIDTH(IDW), .ACC_WIDTH(32)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs2_i       (issue_rs2_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_rd_o       (result_rd_o),
    .result_data_o     (result_data_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IDW-1:0] id;
    logic [4:0]     rd;
    logic [31:0]    data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] acc_m;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rise_cyc = -1;
  bit          hold_rdy = 1'b0;

  initial forever @(posedge clk_i) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, 3'b000, rd, 7'b1111011};
  endfunction

  function automatic bit ref_accept(input logic [31:0] w);
    return (w[6:0] == 7'h7B) && (w[14:12] == 3'd0) && (w[31:25] <= 7'd2);
  endfunction

  function automatic int sprod(input logic [7:0] a, input logic [7:0] b);
    byte sa, sb;
    sa = a;
    sb = b;
    return int'(sa) * int'(sb);
  endfunction

  // Reference result straight from the instruction's arithmetic definition.
  function automatic logic [31:0] ref_result(input logic [31:0] w, input logic [31:0] acc,
                                             input logic [31:0] a, input logic [31:0] b);
    int sum;
    case (w[31:25])
      7'd0: sum = int'(acc) + sprod(a[7:0], b[7:0]);
      7'd1: begin
        sum = int'(acc);
        for (int k = 0; k < 4; k++) sum += sprod(a[8*k +: 8], b[8*k +: 8]);
      end
      default: sum = 0;
    endcase
    return 32'(sum);
  endfunction

  // Random result backpressure unless a test pins ready low.
  initial begin
    result_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      result_ready_i = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare on result handshake, check stability while stalled.
  initial begin
    logic            prev_valid = 1'b0;
    logic            pend = 1'b0;
    logic [IDW-1:0]  p_id;
    logic [4:0]      p_rd;
    logic [31:0]     p_data;
    exp_t            e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_valid = 1'b0;
        pend       = 1'b0;
        continue;
      end
      if (result_valid_o) begin
        if (!prev_valid) rise_cyc = cyc;
        check("ready_low_in_result", 32'(issue_ready_o), 32'd0);
        if (pend) begin
          check("stable_id", 32'(result_id_o), 32'(p_id));
          check("stable_rd", 32'(result_rd_o), 32'(p_rd));
          check("stable_data", result_data_o, p_data);
        end
        if (result_ready_i) begin
          if (sbq.size() == 0) begin
            check("unexpected_result", 32'(result_valid_o), 32'd0);
          end else begin
            e = sbq.pop_front();
            check("result_id", 32'(result_id_o), 32'(e.id));
            check("result_rd", 32'(result_rd_o), 32'(e.rd));
            check("result_data", result_data_o, e.data);
          end
          pend = 1'b0;
        end else begin
          pend   = 1'b1;
          p_id   = result_id_o;
          p_rd   = result_rd_o;
          p_data = result_data_o;
        end
      end else begin
        pend = 1'b0;
      end
      prev_valid = result_valid_o;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (!issue_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_timeout", 32'(issue_ready_o), 32'd1);
  endtask

  // Issue one word, commit (or kill) it d cycles after the handshake.
  task automatic run_txn(input logic [31:0] w, input logic [IDW-1:0] id,
                         input logic [31:0] a, input logic [31:0] b,
                         input int d, input bit kill, input bit junk, output int hs);
    bit   acc_ok;
    exp_t e;
    wait_idle();
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b1;
    issue_instr_i = w;
    issue_id_i    = id;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
    if (d == 0) begin
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
    end else if (junk) begin
      commit_valid_i = 1'b1;
      commit_id_i    = id ^ 4'h1;
      commit_kill_i  = 1'b1;
    end
    @(negedge clk_i);
    hs     = cyc;
    acc_ok = ref_accept(w);
    check("issue_accept", 32'(issue_accept_o), 32'(acc_ok));
    check("issue_writeback", 32'(issue_writeback_o), 32'(acc_ok));
    if (acc_ok && !kill) begin
      e.id   = id;
      e.rd   = w[11:7];
      e.data = ref_result(w, acc_m, a, b);
      acc_m  = e.data;
      sbq.push_back(e);
    end
    for (int c = 1; c <= d; c++) begin
      @(posedge clk_i);
      #1;
      issue_valid_i  = 1'b0;
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      if (c == d) begin
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
      end else if (junk && c == d - 1) begin
        commit_valid_i = 1'b1;
        commit_id_i    = id ^ 4'h1;
        commit_kill_i  = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic check_latency(input string nm, input int hs, input int lat);
    int n = 0;
    while (rise_cyc < hs && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check(nm, 32'(rise_cyc - hs), 32'(lat));
  endtask

  initial begin
    int          hs;
    logic [31:0] w;
    int          sel;
    rst_ni         = 1'b0;
    issue_valid_i  = 1'b0;
    issue_instr_i  = '0;
    issue_id_i     = '0;
    issue_rs1_i    = '0;
    issue_rs2_i    = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    acc_m          = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(issue_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rvalid", 32'(result_valid_o), 32'd0);
    check("rst_rdata", result_data_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("post_rst_ready", 32'(issue_ready_o), 32'd1);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // MAC8 5*7 into a zero accumulator, commit two cycles later
    run_txn(32'h002080FB, 4'd3, 32'd5, 32'd7, 2, 1'b0, 1'b0, hs);
    run_txn(mk_instr(7'd2, 5'd4), 4'd4, 32'd0, 32'd0, 1, 1'b0, 1'b0, hs);

    // DOT4 with commit alongside issue: result 5 cycles after issue
    rise_cyc = -1;
    run_txn(mk_instr(7'd1, 5'd6), 4'd5, 32'h01020304, 32'h05060708, 0, 1'b0, 1'b0, hs);
    check_latency("dot4_latency", hs, 5);
    run_txn(mk_instr(7'd0, 5'd7), 4'd6, 32'd0, 32'd0, 0, 1'b0, 1'b0, hs);
    check_latency("mac8_latency", hs, 2);

    // Signed product and wrap, then clear
    run_txn(mk_instr(7'd2, 5'd1), 4'd7, 32'd0, 32'd0, 0, 1'b0, 1'b0, hs);
    run_txn(mk_instr(7'd0, 5'd2), 4'd8, 32'h000000FF, 32'h00000002, 1, 1'b0, 1'b0, hs);
    rise_cyc = -1;
    run_txn(mk_instr(7'd2, 5'd3), 4'd9, 32'hDEADBEEF, 32'h12345678, 0, 1'b0, 1'b0, hs);
    check_latency("clracc_latency", hs, 2);

    // Kill after a mismatched commit: accumulator keeps 9
    run_txn(mk_instr(7'd0, 5'd5), 4'd1, 32'd3, 32'd3, 1, 1'b0, 1'b0, hs);
    run_txn(mk_instr(7'd0, 5'd5), 4'd2, 32'd5, 32'd7, 3, 1'b1, 1'b1, hs);
    run_txn(mk_instr(7'd0, 5'd8), 4'd3, 32'd0, 32'd0, 2, 1'b0, 1'b1, hs);

    // Rejected words stay in IDLE
    run_txn(32'h00000013, 4'd4, 32'd1, 32'd1, 0, 1'b0, 1'b0, hs);
    check("reject_busy", 32'(busy_o), 32'd0);
    run_txn(mk_instr(7'd3, 5'd1), 4'd5, 32'd1, 32'd1, 0, 1'b0, 1'b0, hs);
    check("reject_f7_busy", 32'(busy_o), 32'd0);
    w = mk_instr(7'd0, 5'd1);
    w[14:12] = 3'd1;
    run_txn(w, 4'd6, 32'd1, 32'd1, 0, 1'b0, 1'b0, hs);

    // Backpressure: result held 3 cycles with ready low
    hold_rdy = 1'b1;
    rise_cyc = -1;
    run_txn(mk_instr(7'd0, 5'd9), 4'd7, 32'hFFFFFF80, 32'h0000007F, 1, 1'b0, 1'b0, hs);
    check_latency("bp_latency", hs, 2);
    repeat (3) @(negedge clk_i);
    check("bp_still_valid", 32'(result_valid_o), 32'd1);
    hold_rdy = 1'b0;

    // Reset during DOT4 lane 2 with commit already seen: no result, acc cleared
    wait_idle();
    @(posedge clk_i);
    #1;
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk_instr(7'd1, 5'd10);
    issue_id_i     = 4'd9;
    issue_rs1_i    = 32'h7F7F7F7F;
    issue_rs2_i    = 32'h7F7F7F7F;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd9;
    commit_kill_i  = 1'b0;
    @(negedge clk_i);
    check("rst_case_accept", 32'(issue_accept_o), 32'd1);
    @(posedge clk_i);
    #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_case_busy", 32'(busy_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ready", 32'(issue_ready_o), 32'd0);
    check("midrst_rvalid", 32'(result_valid_o), 32'd0);
    check("midrst_rdata", result_data_o, 32'd0);
    acc_m = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    run_txn(mk_instr(7'd0, 5'd11), 4'd10, 32'd0, 32'd0, 0, 1'b0, 1'b0, hs);

    // Randomized mix
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      w = mk_instr(7'd0, 5'($urandom));
      else if (sel <= 6) w = mk_instr(7'd1, 5'($urandom));
      else if (sel == 7) w = mk_instr(7'd2, 5'($urandom));
      else if (sel == 8) begin
        w = $urandom;
        w[6:0] = 7'h33;
      end else w = mk_instr(7'($urandom_range(3, 127)), 5'($urandom));
      run_txn(w, 4'($urandom), $urandom, $urandom, $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0), 1'($urandom), hs);
    end

    wait_idle();
    repeat (5) @(negedge clk_i);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
